// File: rtl/freq_meas_ctrl.sv
// Gated frequency-measurement controller: clears, gates and settles an external edge counter, then scales the count to Hz.
// Optional auto-ranging gate selection is enabled with `define FREQ_AUTORANGE_EN.
module freq_meas_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned AUTO_HI    = 10_000_000,
  parameter int unsigned AUTO_LO    = 1_000
) (
  input  logic        in_clk_50M,
  input  logic        in_clr,
  input  logic        start,
  input  logic        cont,
  input  logic [1:0]  range_sel,
  input  logic [31:0] cnt_val,
  input  logic        cnt_ovf,
  output logic        gate_en,
  output logic        cnt_clr,
  output logic [31:0] data_fx,
  output logic [1:0]  rng_used,
  output logic        ovf,
  output logic        valid,
  input  logic        ready,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD} state_t;

  localparam logic [31:0] GATE0_M1  = 32'(CLK_HZ - 1);
  localparam logic [31:0] GATE1_M1  = 32'(CLK_HZ / 10 - 1);
  localparam logic [31:0] GATE2_M1  = 32'(CLK_HZ / 100 - 1);
  localparam logic [31:0] SETTLE_M1 = 32'(SETTLE_CYC - 1);

  state_t      r_state, w_nxt;
  logic [31:0] r_cnt;
  logic [1:0]  r_rng;
  logic        r_ovf_seen;
  logic        r_measured;
  logic [31:0] r_data;
  logic [1:0]  r_rng_used;
  logic        r_ovf;

  logic [1:0]  w_rng_pick;
  logic [31:0] w_gate_m1;
  logic [63:0] w_mult;
  logic [63:0] w_prod;
  logic        w_ovf_now;

`ifdef FREQ_AUTORANGE_EN
  logic [1:0]  r_auto;
  logic        r_auto_mode;
`endif

  always_comb begin
    w_rng_pick = range_sel;
    if (range_sel == 2'd3) begin
`ifdef FREQ_AUTORANGE_EN
      w_rng_pick = r_auto;
`else
      w_rng_pick = 2'd0;
`endif
    end
  end

  always_comb begin
    case (w_rng_pick)
      2'd1:    w_gate_m1 = GATE1_M1;
      2'd2:    w_gate_m1 = GATE2_M1;
      default: w_gate_m1 = GATE0_M1;
    endcase
  end

  always_comb begin
    case (r_rng)
      2'd1:    w_mult = 64'd10;
      2'd2:    w_mult = 64'd100;
      default: w_mult = 64'd1;
    endcase
    w_prod    = {32'd0, cnt_val} * w_mult;
    w_ovf_now = r_ovf_seen | cnt_ovf | (|w_prod[63:32]);
  end

  always_ff @(posedge in_clk_50M or negedge in_clr) begin
    if (!in_clr) r_state <= IDLE;
    else         r_state <= w_nxt;
  end

  // A cont-only start fires once after reset; later runs need start or a cont handshake.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (start || (cont && !r_measured)) w_nxt = CLEAR;
      CLEAR:   w_nxt = GATE;
      GATE:    if (r_cnt == 32'd0) w_nxt = SETTLE;
      SETTLE:  if (r_cnt == 32'd0) w_nxt = LATCH;
      LATCH:   w_nxt = HOLD;
      HOLD:    if (ready) w_nxt = cont ? CLEAR : IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  assign gate_en  = (r_state == GATE);
  assign cnt_clr  = (r_state == CLEAR);
  assign valid    = (r_state == HOLD);
  assign busy     = (r_state != IDLE);
  assign data_fx  = r_data;
  assign rng_used = r_rng_used;
  assign ovf      = r_ovf;

  always_ff @(posedge in_clk_50M or negedge in_clr) begin
    if (!in_clr) begin
      r_cnt       <= 32'd0;
      r_rng       <= 2'd0;
      r_ovf_seen  <= 1'b0;
      r_measured  <= 1'b0;
      r_data      <= 32'd0;
      r_rng_used  <= 2'd0;
      r_ovf       <= 1'b0;
`ifdef FREQ_AUTORANGE_EN
      r_auto      <= 2'd0;
      r_auto_mode <= 1'b0;
`endif
    end else begin
      case (r_state)
        CLEAR: begin
          r_rng      <= w_rng_pick;
          r_cnt      <= w_gate_m1;
          r_ovf_seen <= 1'b0;
`ifdef FREQ_AUTORANGE_EN
          r_auto_mode <= (range_sel == 2'd3);
`endif
        end
        GATE: begin
          r_ovf_seen <= r_ovf_seen | cnt_ovf;
          r_cnt      <= (r_cnt == 32'd0) ? SETTLE_M1 : r_cnt - 32'd1;
        end
        SETTLE: begin
          r_ovf_seen <= r_ovf_seen | cnt_ovf;
          if (r_cnt != 32'd0) r_cnt <= r_cnt - 32'd1;
        end
        LATCH: begin
          r_data     <= w_ovf_now ? 32'hFFFF_FFFF : w_prod[31:0];
          r_rng_used <= r_rng;
          r_ovf      <= w_ovf_now;
          r_measured <= 1'b1;
`ifdef FREQ_AUTORANGE_EN
          if (r_auto_mode) begin
            if ((cnt_val > 32'(AUTO_HI) || w_ovf_now) && r_auto < 2'd2) r_auto <= r_auto + 2'd1;
            else if (cnt_val < 32'(AUTO_LO) && r_auto > 2'd0)           r_auto <= r_auto - 2'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Scoreboard bench for freq_meas_ctrl with a 1000-cycle 1 s gate and 4-cycle settle.
module tb_freq_meas_ctrl;
  logic        in_clk_50M = 1'b0;
  logic        in_clr = 1'b0;
  logic        start = 1'b0, cont = 1'b0, cnt_ovf = 1'b0, ready = 1'b1;
  logic [1:0]  range_sel = 2'd0;
  logic [31:0] cnt_val = 32'd0;
  logic        gate_en, cnt_clr, ovf, valid, busy;
  logic [31:0] data_fx;
  logic [1:0]  rng_used;

  typedef struct packed { logic [31:0] d; logic [1:0] r; logic o; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  freq_meas_ctrl #(.CLK_HZ(1000), .SETTLE_CYC(4)) dut (
    .in_clk_50M(in_clk_50M), .in_clr(in_clr), .start(start), .cont(cont),
    .range_sel(range_sel), .cnt_val(cnt_val), .cnt_ovf(cnt_ovf),
    .gate_en(gate_en), .cnt_clr(cnt_clr), .data_fx(data_fx), .rng_used(rng_used),
    .ovf(ovf), .valid(valid), .ready(ready), .busy(busy));

  always #5 in_clk_50M = ~in_clk_50M;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge in_clk_50M) begin
    if (cnt_clr && gate_en) check("clr_gate_excl", 1, 0);
    if (valid && ready) begin
      if (sb.size() == 0) check("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("data_fx", data_fx, e.d);
        check("rng_used", rng_used, e.r);
        check("ovf", ovf, e.o);
      end
    end
  end

  // Start one measurement; return once valid is seen (the handshake edge is next if ready=1).
  task automatic measure(input logic [1:0] rs, input logic [31:0] cv, input logic [31:0] ed,
                         input logic [1:0] er, input logic eo, input int glen, input bit inj);
    int lat, gc;
    bit done;
    @(posedge in_clk_50M); #1;
    range_sel = rs; cnt_val = cv; start = 1'b1;
    sb.push_back('{ed, er, eo});
    lat = 0; gc = 0; done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge in_clk_50M); #1;
      start = 1'b0; lat++;
      if (gate_en) gc++;
      cnt_ovf = inj && (gc == 3);
      if (valid) done = 1;
    end
    cnt_ovf = 1'b0;
    check("latency", lat, glen + 7);
    check("gate_len", gc, glen);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc;
    repeat (2) @(negedge in_clr ? in_clk_50M : in_clk_50M);
    check("rst_gate_en", gate_en, 0);
    check("rst_cnt_clr", cnt_clr, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data_fx, 0);
    check("rst_rng", rng_used, 0);
    check("rst_ovf", ovf, 0);
    @(posedge in_clk_50M); #1 in_clr = 1'b1;

    // 1 s gate, plain count
    measure(2'd0, 32'd250, 32'd250, 2'd0, 1'b0, 1000, 1'b0);
    @(posedge in_clk_50M); #1;
    check("idle_after_hs", busy, 0);

    // 10 ms gate, consumer stalls; result must hold and start is ignored
    ready = 1'b0;
    measure(2'd2, 32'd7, 32'd700, 2'd2, 1'b0, 10, 1'b0);
    cnt_val = 32'd999; start = 1'b1;
    repeat (5) begin @(posedge in_clk_50M); #1; start = 1'b0; end
    check("hold_valid", valid, 1);
    check("hold_data", data_fx, 700);
    check("hold_rng", rng_used, 2);
    ready = 1'b1;
    @(posedge in_clk_50M); #1;
    check("start_in_hold_dropped", busy, 0);

    // 100 ms gate, product overflow; start coincides with handshake
    measure(2'd1, 32'h2000_0000, 32'hFFFF_FFFF, 2'd1, 1'b1, 100, 1'b0);
    start = 1'b1;
    @(posedge in_clk_50M); #1; start = 1'b0;
    check("start_at_hs_dropped", busy, 0);

    // datapath overflow pulse mid-gate is sticky
    measure(2'd0, 32'd5, 32'hFFFF_FFFF, 2'd0, 1'b1, 1000, 1'b1);
    // range 3 with auto register at 0 behaves as 1 s gate in both builds
    measure(2'd3, 32'd123, 32'd123, 2'd0, 1'b0, 1000, 1'b0);

    // reset at gate cycle 500
    @(posedge in_clk_50M); #1;
    range_sel = 2'd0; cnt_val = 32'd250; start = 1'b1;
    gc = 0;
    for (int i = 0; i < 1200 && gc < 500; i++) begin
      @(posedge in_clk_50M); #1; start = 1'b0;
      if (gate_en) gc++;
    end
    check("gate_reached_500", gc, 500);
    #3 in_clr = 1'b0;
    #1;
    check("rst_mid_gate_en", gate_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_clr", cnt_clr, 0);
    repeat (3) @(posedge in_clk_50M);
    #1 in_clr = 1'b1;
    repeat (20) @(posedge in_clk_50M);
    #1;
    check("no_partial_valid", valid, 0);
    check("no_partial_busy", busy, 0);
    measure(2'd2, 32'd3, 32'd300, 2'd2, 1'b0, 10, 1'b0);

    // continuous mode, back-to-back with one CLEAR cycle between
    cont = 1'b1;
    @(posedge in_clk_50M); #1;
    for (int k = 0; k < 3; k++) sb.push_back('{32'd700, 2'd2, 1'b0});
    range_sel = 2'd2; cnt_val = 32'd7; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit done;
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
        @(posedge in_clk_50M); #1; start = 1'b0;
        if (valid) done = 1;
      end
      check("cont_valid_seen", done, 1);
      if (k < 2) begin
        @(posedge in_clk_50M); #1;
        check("cont_clear", cnt_clr, 1);
        check("cont_clear_novalid", valid, 0);
        @(posedge in_clk_50M); #1;
        check("cont_gate", gate_en, 1);
        start = 1'b1;
      end else begin
        cont = 1'b0;
        @(posedge in_clk_50M); #1;
        check("cont_stop_idle", busy, 0);
      end
    end
    repeat (30) @(posedge in_clk_50M);
    #1;
    check("no_queued_start", busy, 0);

`ifdef FREQ_AUTORANGE_EN
    measure(2'd3, 32'd20_000_000, 32'd20_000_000, 2'd0, 1'b0, 1000, 1'b0);
    measure(2'd3, 32'd20_000_000, 32'd200_000_000, 2'd1, 1'b0, 100, 1'b0);
    measure(2'd3, 32'd20_000_000, 32'd2_000_000_000, 2'd2, 1'b0, 10, 1'b0);
    measure(2'd3, 32'd20_000_000, 32'd2_000_000_000, 2'd2, 1'b0, 10, 1'b0);
`endif
    repeat (3) @(posedge in_clk_50M);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
